// File: rtl/cv32e40p_cg_ctrl.sv
// cv32e40p_cg_ctrl: per-domain clock-gate controller with idle hysteresis, wake settle and force-on
module cv32e40p_cg_ctrl #(
   parameter int unsigned        NUM_CH    = 2,
   parameter int unsigned        IDLE_HOLD = 4,
   parameter int unsigned        WAKE_LAT  = 1,
   parameter logic [NUM_CH-1:0]  RESET_ON  = '1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              scan_cg_en_i,
   input  logic [NUM_CH-1:0] busy_i,
   input  logic [NUM_CH-1:0] wake_i,
   input  logic [NUM_CH-1:0] force_on_i,
   output logic [NUM_CH-1:0] clk_en_o,
   output logic [NUM_CH-1:0] ready_o,
   output logic [NUM_CH-1:0] gated_o,
   output logic              all_gated_o
);
   localparam int unsigned MAX_LD = (IDLE_HOLD > WAKE_LAT) ? IDLE_HOLD : WAKE_LAT;
   localparam int unsigned CW = (MAX_LD < 2) ? 1 : $clog2(MAX_LD + 1);
   localparam logic [CW-1:0] HOLD_LD = CW'((IDLE_HOLD > 0) ? IDLE_HOLD - 1 : 0);
   localparam logic [CW-1:0] WAKE_LD = CW'((WAKE_LAT > 0) ? WAKE_LAT - 1 : 0);

   typedef enum logic [1:0] {RUN = 2'b00, HOLD = 2'b01, OFF = 2'b10, WAKE = 2'b11} state_e;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_e        st, st_nxt;
      logic [CW-1:0] cnt, cnt_nxt;
      logic          act;

      assign act = busy_i[i] | wake_i[i] | force_on_i[i];

      // state and counter registers; reset picks RUN or OFF per channel
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            st  <= RESET_ON[i] ? RUN : OFF;
            cnt <= '0;
         end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
         end
      end

      // next state: idle countdown in HOLD, unconditional settle countdown in WAKE
      always_comb begin
         st_nxt  = st;
         cnt_nxt = cnt;
         case (st)
            RUN:
               if (!act) begin
                  st_nxt  = (IDLE_HOLD == 0) ? OFF : HOLD;
                  cnt_nxt = HOLD_LD;
               end
            HOLD:
               if (act) st_nxt = RUN;
               else if (cnt == '0) st_nxt = OFF;
               else cnt_nxt = cnt - CW'(1);
            OFF:
               if (act) begin
                  st_nxt  = (WAKE_LAT == 0) ? RUN : WAKE;
                  cnt_nxt = WAKE_LD;
               end
            WAKE:
               if (cnt == '0) st_nxt = RUN;
               else cnt_nxt = cnt - CW'(1);
            default: st_nxt = RUN;
         endcase
      end

      assign clk_en_o[i] = (st != OFF) | scan_cg_en_i;
      assign ready_o[i]  = (st == RUN) | (st == HOLD);
      assign gated_o[i]  = (st == OFF);
   end

   assign all_gated_o = &gated_o;
endmodule

// File: tb/tb_cv32e40p_cg_ctrl.sv
// tb_cv32e40p_cg_ctrl: two parameter sets against a cycle-count model plus directed literal checks
module tb_cv32e40p_cg_ctrl;
   logic       clk = 0, rst_n = 1, scan = 0;
   logic [1:0] busy = 0, wake = 0, force_on = 0, act;
   logic [1:0] a_en, a_rdy, a_gt, b_en, b_rdy, b_gt;
   logic       a_all, b_all;
   int         checks = 0, errors = 0;
   bit         chk_on = 0;

   typedef struct packed {logic en; logic rdy; logic [7:0] idle; logic [7:0] age;} ch_t;
   ch_t ma [2];
   ch_t mb [2];

   always #5 clk = ~clk;
   assign act = busy | wake | force_on;

   cv32e40p_cg_ctrl #(.NUM_CH(2), .IDLE_HOLD(4), .WAKE_LAT(2), .RESET_ON(2'b01)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .scan_cg_en_i(scan), .busy_i(busy), .wake_i(wake),
      .force_on_i(force_on), .clk_en_o(a_en), .ready_o(a_rdy), .gated_o(a_gt), .all_gated_o(a_all));

   cv32e40p_cg_ctrl #(.NUM_CH(2), .IDLE_HOLD(0), .WAKE_LAT(0), .RESET_ON(2'b10)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .scan_cg_en_i(scan), .busy_i(busy), .wake_i(wake),
      .force_on_i(force_on), .clk_en_o(b_en), .ready_o(b_rdy), .gated_o(b_gt), .all_gated_o(b_all));

   function automatic ch_t rst_val(input logic on);
      return {on, on, 8'd0, 8'd0};
   endfunction

   // one clock of a channel: enable on first active edge, ready after wl more edges,
   // off once more than ih consecutive idle edges have been seen while ready
   function automatic ch_t step(input ch_t s, input logic a, input int ih, input int wl);
      ch_t n = s;
      if (!s.en) begin
         if (a) begin
            n.en = 1; n.rdy = (wl == 0); n.age = 0; n.idle = 0;
         end
      end else if (!s.rdy) begin
         n.age = s.age + 8'd1;
         if (int'(n.age) == wl) begin
            n.rdy = 1; n.idle = 0;
         end
      end else if (a) n.idle = 0;
      else begin
         n.idle = s.idle + 8'd1;
         if (int'(n.idle) > ih) begin
            n.en = 0; n.rdy = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma[0] <= rst_val(1); ma[1] <= rst_val(0);
         mb[0] <= rst_val(0); mb[1] <= rst_val(1);
      end else begin
         for (int c = 0; c < 2; c++) begin
            ma[c] <= step(ma[c], act[c], 4, 2);
            mb[c] <= step(mb[c], act[c], 0, 0);
         end
      end
   end

   task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("m_a_en", a_en, {ma[1].en, ma[0].en} | {2{scan}});
         chk("m_a_rdy", a_rdy, {ma[1].rdy, ma[0].rdy});
         chk("m_a_gated", a_gt, ~{ma[1].en, ma[0].en});
         chk("m_a_all", {1'b0, a_all}, {1'b0, ~ma[1].en & ~ma[0].en});
         chk("m_b_en", b_en, {mb[1].en, mb[0].en} | {2{scan}});
         chk("m_b_rdy", b_rdy, {mb[1].rdy, mb[0].rdy});
         chk("m_b_gated", b_gt, ~{mb[1].en, mb[0].en});
         chk("m_b_all", {1'b0, b_all}, {1'b0, ~mb[1].en & ~mb[0].en});
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 0;
      tick(2);
      chk_on = 1;
      chk("rst_a_en", a_en, 2'b01);
      chk("rst_a_gated", a_gt, 2'b10);
      chk("rst_a_rdy", a_rdy, 2'b01);
      chk("rst_b_en", b_en, 2'b10);
      chk("rst_b_gated", b_gt, 2'b01);
      rst_n = 1;
      tick();
      chk("b_idle0_gated", b_gt, 2'b11);
      tick(3);
      chk("a_hold_en", a_en, 2'b01);
      tick();
      chk("a_idle_gated", a_gt, 2'b11);
      chk("a_all_gated", {1'b0, a_all}, 2'b01);

      busy[0] = 1;
      tick();
      chk("wake_a_en0", a_en, 2'b01);
      chk("wake_a_rdy0", a_rdy, 2'b00);
      chk("wake_b_rdy0", b_rdy, 2'b01);
      tick(2);
      chk("wake_a_rdy0_late", a_rdy, 2'b01);
      busy[0] = 0;
      tick(4);
      chk("hyst_en_t14", a_en, 2'b01);
      tick();
      chk("hyst_en_t15", a_en, 2'b00);

      busy[0] = 1;
      tick(3);
      busy[0] = 0;
      tick(3);
      busy[0] = 1;
      tick();
      chk("pulse_en", a_en, 2'b01);
      busy[0] = 0;
      tick(4);
      chk("reidle_en_t18", a_en, 2'b01);
      tick();
      chk("reidle_en_t19", a_en, 2'b00);

      wake[1] = 1;
      tick();
      chk("wl2_en1", a_en, 2'b10);
      chk("wl2_rdy1", a_rdy, 2'b00);
      chk("wl0_rdy1", b_rdy, 2'b10);
      wake[1] = 0;
      tick();
      chk("wl2_rdy_t22", a_rdy, 2'b00);
      chk("ih0_gated_b1", b_gt, 2'b11);
      tick();
      chk("wl2_rdy_t23", a_rdy, 2'b10);
      tick(4);
      chk("wl2_reidle_hold", a_gt, 2'b01);
      tick();
      chk("wl2_reidle_off", a_gt, 2'b11);

      force_on[0] = 1;
      for (int k = 0; k < 100; k++) begin
         tick();
         chk("force_a_gated0", {1'b0, a_gt[0]}, 2'b00);
         chk("force_b_gated0", {1'b0, b_gt[0]}, 2'b00);
      end
      force_on[0] = 0;
      tick(6);
      chk("force_rel_gated", a_gt, 2'b11);

      scan = 1;
      #1;
      chk("scan_a_en", a_en, 2'b11);
      chk("scan_a_gated", a_gt, 2'b11);
      chk("scan_b_en", b_en, 2'b11);
      scan = 0;
      #1;
      chk("scan_off_a_en", a_en, 2'b00);

      wake[1] = 1;
      tick();
      wake[1] = 0;
      chk("mid_wake_en", a_en, 2'b10);
      #1 rst_n = 0;
      #1;
      chk("async_a_en", a_en, 2'b01);
      chk("async_a_rdy", a_rdy, 2'b01);
      chk("async_a_gated", a_gt, 2'b10);
      chk("async_b_en", b_en, 2'b10);
      tick();
      rst_n = 1;

      for (int k = 0; k < 3000; k++) begin
         bit quiet = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < 2; c++) begin
            busy[c] = !quiet && ($urandom_range(0, 5) == 0);
            wake[c] = !quiet && ($urandom_range(0, 11) == 0);
            force_on[c] = ($urandom_range(0, 63) == 0);
         end
         scan = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 0;
            tick();
            rst_n = 1;
         end else tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
